// File: rtl/wino_tile_feeder_if.sv
// wino_tile_feeder_if
//   Bundles the kernel write port, the raster pixel stream and the tile stream
//   of the Winograd tile feeder.
//   Parameters IMG_W / IMG_H size the tile_col / tile_row coordinates and must
//   match the feeder instance that uses this interface.
//   Modports:
//     master - the feeder side: consumes kernel writes and pixels, produces tiles
//     slave  - the surrounding system: writes kernel, sources pixels, sinks tiles
interface wino_tile_feeder_if #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) ();
  logic                       ker_we;
  logic [3:0]                 ker_addr;
  logic [7:0]                 ker_data;

  logic                       pix_valid;
  logic                       pix_ready;
  logic [7:0]                 pix_data;

  logic                       tile_valid;
  logic                       tile_ready;
  logic [127:0]               tile_data;
  logic [71:0]                tile_ker;
  logic [$clog2(IMG_H)-1:0]   tile_row;
  logic [$clog2(IMG_W)-1:0]   tile_col;
  logic                       tile_last;

  modport master (
    input  ker_we, ker_addr, ker_data,
    input  pix_valid, pix_data,
    output pix_ready,
    output tile_valid, tile_data, tile_ker, tile_row, tile_col, tile_last,
    input  tile_ready
  );

  modport slave (
    output ker_we, ker_addr, ker_data,
    output pix_valid, pix_data,
    input  pix_ready,
    input  tile_valid, tile_data, tile_ker, tile_row, tile_col, tile_last,
    output tile_ready
  );
endinterface

// File: rtl/wino_tile_feeder.sv
// wino_tile_feeder
//   Upstream feeder for an F(2x2,3x3) Winograd core. Takes a raster-order
//   8-bit feature-map stream, keeps the last four image rows in a ring buffer
//   (image row r lives in slot r mod 4) and, each time a two-row band is
//   complete, presents every stride-2 4x4 input tile of that band together
//   with the 3x3 kernel latched at the start of the frame.
//
//   Parameters
//     IMG_W, IMG_H  feature-map width/height in pixels (even, >= 4)
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     bus        wino_tile_feeder_if.master:
//                  ker_we/ker_addr/ker_data  working-kernel write (addr 0..8)
//                  pix_valid/pix_ready/pix_data  pixel stream in
//                  tile_valid/tile_ready     tile handshake out
//                  tile_data   16 bytes, byte 4*i+j = tile row i, col j
//                  tile_ker    9 bytes, byte 3*i+j = kernel row i, col j
//                  tile_row    top image row of the tile (even)
//                  tile_col    left image column of the tile (even)
//                  tile_last   final tile of the frame
//     tile_cnt   (WINO_FEED_STATS_EN only) tiles accepted, saturating
//     stall_cnt  (WINO_FEED_STATS_EN only) cycles with tile_valid & !tile_ready,
//                saturating
//
//   Build option: define WINO_FEED_STATS_EN to add the tile_cnt / stall_cnt
//   statistics outputs; without it those ports and counters do not exist.
module wino_tile_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                clk,
  input  logic                rst,
`ifdef WINO_FEED_STATS_EN
  output logic [15:0]         tile_cnt,
  output logic [15:0]         stall_cnt,
`endif
  wino_tile_feeder_if.master  bus
);

  localparam int DATA_W = 8;
  localparam int KN     = 9;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [0:0]        state;
  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic [RW-1:0]     tile_row_q;
  logic [CW-1:0]     tile_col_q;

  logic [DATA_W-1:0] ring      [4][IMG_W];
  logic [DATA_W-1:0] ker_work  [KN];
  logic [DATA_W-1:0] ker_frame [KN];

  logic              pix_ready_c;
  logic              tile_valid_c;
  logic              pix_acc;
  logic              tile_acc;
  logic              col_last;
  logic              band_done;
  logic              band_end;
  logic              frame_end;
  logic              frame_start;
  logic [127:0]      tile_gather;
  logic [71:0]       ker_flat;

  // Ready is forced low while rst is high so nothing is taken in the reset cycle.
  assign pix_ready_c  = (state == ST_FILL) && !rst;
  assign tile_valid_c = (state == ST_EMIT);

  assign pix_acc  = bus.pix_valid && pix_ready_c;
  assign tile_acc = tile_valid_c && bus.tile_ready;

  assign col_last    = (col_cnt == CW'(IMG_W - 1));
  assign frame_start = pix_acc && (row_cnt == '0) && (col_cnt == '0);

  // A band is ready once four rows are buffered and the newest row is odd:
  // row 3 for the first band, then rows 5, 7, ... for the following ones.
  assign band_done = pix_acc && col_last && row_cnt[0] && (row_cnt >= RW'(3));

  assign band_end  = (tile_col_q == CW'(IMG_W - 4));
  assign frame_end = band_end && (tile_row_q == RW'(IMG_H - 4));

  // Control: FILL/EMIT sequencing and raster / tile position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FILL;
      col_cnt    <= '0;
      row_cnt    <= '0;
      tile_row_q <= '0;
      tile_col_q <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (pix_acc) begin
            if (col_last) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + RW'(1);
            end else begin
              col_cnt <= col_cnt + CW'(1);
            end
          end
          if (band_done) begin
            state      <= ST_EMIT;
            tile_row_q <= row_cnt - RW'(3);
            tile_col_q <= '0;
          end
        end
        ST_EMIT: begin
          if (tile_acc) begin
            if (band_end) begin
              state      <= ST_FILL;
              tile_col_q <= '0;
              if (frame_end) begin
                row_cnt <= '0;
                col_cnt <= '0;
              end
            end else begin
              tile_col_q <= tile_col_q + CW'(2);
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  // Row ring: pure data storage, written only when a pixel is accepted
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      ring[row_cnt[1:0]][col_cnt] <= bus.pix_data;
    end
  end

  // Kernel registers. The frame copy is taken from the pre-edge working
  // values, so a write landing together with pixel (0,0) only affects the
  // next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < KN; k++) begin
        ker_work[k]  <= '0;
        ker_frame[k] <= '0;
      end
    end else begin
      for (int k = 0; k < KN; k++) begin
        if (bus.ker_we && (bus.ker_addr == 4'(k))) begin
          ker_work[k] <= bus.ker_data;
        end
        if (frame_start) begin
          ker_frame[k] <= ker_work[k];
        end
      end
    end
  end

  // Tile gather: ring slot wraps with the 2-bit row index; columns never
  // overflow because tile_col stays <= IMG_W-4.
  always_comb begin
    logic [1:0]    slot;
    logic [CW-1:0] cidx;
    tile_gather = '0;
    slot        = '0;
    cidx        = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        slot = tile_row_q[1:0] + 2'(i);
        cidx = tile_col_q + CW'(j);
        tile_gather[8*(4*i+j) +: 8] = ring[slot][cidx];
      end
    end
  end

  always_comb begin
    ker_flat = '0;
    for (int k = 0; k < KN; k++) begin
      ker_flat[8*k +: 8] = ker_frame[k];
    end
  end

  assign bus.pix_ready  = pix_ready_c;
  assign bus.tile_valid = tile_valid_c;
  // Data is blanked outside EMIT so the reset/idle value is all zeros.
  assign bus.tile_data  = tile_valid_c ? tile_gather : '0;
  assign bus.tile_ker   = ker_flat;
  assign bus.tile_row   = tile_row_q;
  assign bus.tile_col   = tile_col_q;
  assign bus.tile_last  = tile_valid_c && frame_end;

`ifdef WINO_FEED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (tile_acc) begin
        tile_cnt <= sat_inc(tile_cnt);
      end
      if (tile_valid_c && !bus.tile_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end
`endif

endmodule

// File: doc/wino_tile_feeder.md
# wino_tile_feeder

Upstream feeder for the F(2x2,3x3) Winograd core. Accepts a raster-order 8-bit feature-map stream and a 9-byte kernel, buffers rows, and presents overlapping 4x4 input tiles (stride 2) plus the 3x3 kernel through a valid/ready handshake. Each accepted tile maps to one 2x2 output block of the Winograd core.

## Interface
- IMG_W, 8, feature-map width in pixels; even, >= 4
- IMG_H, 8, feature-map height in pixels; even, >= 4
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- ker_we  in  1  kernel write strobe
- ker_addr  in  4  kernel index 0..8 (3*row+col); 9..15 ignored
- ker_data  in  8  kernel byte
- pix_valid  in  1  pixel present
- pix_ready  out  1  feeder accepts pixel this cycle
- pix_data  in  8  pixel, raster order, row 0 col 0 first
- tile_valid  out  1  tile outputs valid
- tile_ready  in  1  consumer accepts tile
- tile_data  out  128  byte 4*i+j at [8*(4i+j)+7:8*(4i+j)] = tile row i, col j
- tile_ker  out  72  byte 3*i+j = frame kernel row i, col j
- tile_row  out  $clog2(IMG_H)  top image row of tile (even)
- tile_col  out  $clog2(IMG_W)  left image column of tile (even)
- tile_last  out  1  last tile of frame

## Operation
- Storage: 4-row ring, IMG_W bytes per row; image row r goes to slot r mod 4. Working kernel (9 regs) and frame kernel (9 regs).
- ker_we writes working kernel any cycle. Frame kernel loads from working kernel on acceptance of pixel (0,0); tile_ker always drives frame kernel. A write in the same cycle as pixel (0,0) acceptance is not seen by that frame.
- FSM FILL: pix_ready=1, tile_valid=0. Pixel accepted on pix_valid&pix_ready; column counter wraps IMG_W-1 -> 0 and increments row. Band ready when row 3 (first band) or any odd row r >= 5 completes; go to EMIT.
- FSM EMIT: pix_ready=0, tile_valid=1. tile_row = bottom completed row - 3; tile_col starts at 0, +2 per accepted tile. tile_data from slots (tile_row+i) mod 4, columns tile_col+j.
- Tiles per band = (IMG_W-2)/2; bands per frame = (IMG_H-2)/2. tile_last=1 on final tile of final band.
- After last tile of a band: FILL. After tile_last accepted: row/col counters to 0, FILL for new frame (next pixel is (0,0)).
- Arithmetic: none on pixel data; bytes pass through unsigned/unmodified.

## Timing
- Reset values: pix_ready=0 during rst cycle, 1 from first cycle after; tile_valid=0, tile_data=0, tile_ker=0, tile_row=0, tile_col=0, tile_last=0; both kernel sets 0; state FILL; counters 0.
- Latency: tile_valid rises the cycle after the band-completing pixel is accepted.
- Throughput: one tile per cycle with tile_ready held high; pix_ready returns 1 the cycle after the band's last tile is accepted.
- Handshake: once tile_valid=1, all tile outputs hold stable until tile_valid&tile_ready; tile_valid never drops without acceptance (except rst).
- Pixels offered in EMIT are not accepted (pix_ready=0); source must hold.
- rst mid-frame or mid-EMIT: partial frame discarded, outputs to reset values next cycle; next accepted pixel is (0,0).

## Configuration
- WINO_FEED_STATS_EN defined: adds outputs tile_cnt[15:0] (tiles accepted since reset) and stall_cnt[15:0] (cycles with tile_valid=1, tile_ready=0); both saturate at 16'hFFFF, reset to 0.
- Undefined: ports and counters absent; remaining behaviour identical.

## Test plan
- IMG_W=IMG_H=4, pixels 1..16, kernel 1..9, tile_ready=1 -> one tile, tile_data bytes 1..16, tile_ker bytes 1..9, tile_row=0, tile_col=0, tile_last=1, valid the cycle after pixel 16.
- IMG_W=IMG_H=8, pixel = 8*r+c -> 9 tiles; tile at (2,4) byte 0 = 20, byte 15 = 47; tile_last only on (4,4); pix_ready=0 during each band.
- Backpressure: tile_ready low 5 cycles on tile 2 of 8x8 -> tile_data/tile_col frozen 5 cycles, stall_cnt=5 (STATS_EN), no tile lost.
- Kernel write (addr 4, 0xAA) after pixel (0,0) -> current frame tile_ker byte 4 unchanged; next frame shows 0xAA.
- rst asserted mid-EMIT of 8x8 frame -> all outputs reset next cycle; fresh 4x4 frame then produces correct single tile.
- Two consecutive 8x8 frames -> 18 tiles, tile_cnt=18 (STATS_EN), second frame tile_row restarts at 0.
